rocketcpu_gpio_bank: RTL and testbench

Parametrised Wishbone GPIO bank for the RocketCPU SoC, generalising the single-pin GPIO peripheral to `WIDTH` pins. Each pin has an output latch, a direction bit, a two-flop input synchroniser with configurable polarity, and an optional rising-edge interrupt. The block sits on the CPU's Wishbone data bus beside the other memory-mapped peripherals and drives one `o_irq` line to the interrupt controller.

---
 rtl/rocketcpu_gpio_pkg.sv | 12 +
 rtl/rocketcpu_gpio_sync.sv | 42 ++++
 rtl/rocketcpu_gpio_bank.sv | 112 +++++++++++
 tb/tb_rocketcpu_gpio_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rocketcpu_gpio_pkg.sv
// rtl/rocketcpu_gpio_pkg.sv - GPIO bank register word addresses
package rocketcpu_gpio_pkg;

  localparam int GPIO_ADR_W = 3;

  localparam logic [GPIO_ADR_W-1:0] GPIO_ADR_OUT  = 3'd0;
  localparam logic [GPIO_ADR_W-1:0] GPIO_ADR_DIR  = 3'd1;
  localparam logic [GPIO_ADR_W-1:0] GPIO_ADR_IN   = 3'd2;
  localparam logic [GPIO_ADR_W-1:0] GPIO_ADR_PEND = 3'd3;
  localparam logic [GPIO_ADR_W-1:0] GPIO_ADR_MASK = 3'd4;

endpackage

// File: rtl/rocketcpu_gpio_sync.sv
// rtl/rocketcpu_gpio_sync.sv - per-pin inversion, two-flop synchroniser, rising-edge detect
// Edge flop only exists with ROCKETCPU_GPIO_IRQ_EN; otherwise rise is tied 0.
module rocketcpu_gpio_sync #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] IN_INVERT = '0
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst,
  input  logic [WIDTH-1:0] i_gpio,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_gpio ^ IN_INVERT;
      sync_q <= meta_q;
    end
  end

  assign sync = sync_q;

`ifdef ROCKETCPU_GPIO_IRQ_EN
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) prev_q <= '0;
    else          prev_q <= sync_q;
  end

  assign rise = sync_q & ~prev_q;
`else
  assign rise = '0;
`endif

endmodule

// File: rtl/rocketcpu_gpio_bank.sv
// rtl/rocketcpu_gpio_bank.sv - Wishbone GPIO bank: OUT/DIR/IN registers, optional edge interrupt
// Interrupt logic (PEND, MASK, o_irq) is built only with ROCKETCPU_GPIO_IRQ_EN.
module rocketcpu_gpio_bank
  import rocketcpu_gpio_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] OUT_RESET = '0,
  parameter logic [WIDTH-1:0] IN_INVERT = '0
) (
  input  logic                  i_wb_clk,
  input  logic                  i_wb_rst,
  input  logic [GPIO_ADR_W-1:0] i_wb_adr,
  input  logic [31:0]           i_wb_dat,
  input  logic                  i_wb_we,
  input  logic                  i_wb_cyc,
  output logic [31:0]           o_wb_rdt,
  output logic                  o_wb_ack,
  output logic [WIDTH-1:0]      o_gpio,
  output logic [WIDTH-1:0]      o_gpio_oe,
  input  logic [WIDTH-1:0]      i_gpio,
  output logic                  o_irq
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] wr_data;
  logic [31:0]      rd_word;
  logic             access;
  logic             wr;
  logic             unused_dat;

  rocketcpu_gpio_sync #(
    .WIDTH     (WIDTH),
    .IN_INVERT (IN_INVERT)
  ) u_sync (
    .i_wb_clk (i_wb_clk),
    .i_wb_rst (i_wb_rst),
    .i_gpio   (i_gpio),
    .sync     (sync),
    .rise     (rise)
  );

  // Every cycle/ack pair is one transfer; a held cyc yields one transfer per two cycles.
  assign access     = i_wb_cyc & ~o_wb_ack;
  assign wr         = access & i_wb_we;
  assign wr_data    = i_wb_dat[WIDTH-1:0];
  assign unused_dat = ^i_wb_dat;

`ifdef ROCKETCPU_GPIO_IRQ_EN
  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] pend_clr;

  assign pend_clr = (wr && i_wb_adr == GPIO_ADR_PEND) ? wr_data : '0;

  // A new edge in the same cycle as a clear keeps the bit set.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      pend_q <= '0;
      mask_q <= '0;
      o_irq  <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~pend_clr) | rise;
      if (wr && i_wb_adr == GPIO_ADR_MASK) mask_q <= wr_data;
      o_irq  <= |(pend_q & mask_q);
    end
  end
`else
  logic unused_rise;
  assign unused_rise = ^rise;
  assign o_irq       = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    case (i_wb_adr)
      GPIO_ADR_OUT:  rd_word[WIDTH-1:0] = out_q;
      GPIO_ADR_DIR:  rd_word[WIDTH-1:0] = dir_q;
      GPIO_ADR_IN:   rd_word[WIDTH-1:0] = sync;
`ifdef ROCKETCPU_GPIO_IRQ_EN
      GPIO_ADR_PEND: rd_word[WIDTH-1:0] = pend_q;
      GPIO_ADR_MASK: rd_word[WIDTH-1:0] = mask_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      out_q    <= OUT_RESET;
      dir_q    <= '0;
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
    end else begin
      o_wb_ack <= access;
      o_wb_rdt <= (access && !i_wb_we) ? rd_word : '0;
      if (wr) begin
        case (i_wb_adr)
          GPIO_ADR_OUT: out_q <= wr_data;
          GPIO_ADR_DIR: dir_q <= wr_data;
          default: ;
        endcase
      end
    end
  end

  assign o_gpio    = out_q;
  assign o_gpio_oe = dir_q;

endmodule

// File: tb/tb_rocketcpu_gpio_bank.sv
// tb/tb_rocketcpu_gpio_bank.sv - scoreboard bench for rocketcpu_gpio_bank (either ROCKETCPU_GPIO_IRQ_EN build)
module tb_rocketcpu_gpio_bank;

  localparam int         WIDTH   = 8;
  localparam logic [7:0] OUT_RST = 8'hA5;
  localparam logic [7:0] INV     = 8'h01;
`ifdef ROCKETCPU_GPIO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       i_wb_adr;
  logic [31:0]      i_wb_dat;
  logic             i_wb_we;
  logic             i_wb_cyc;
  logic [31:0]      o_wb_rdt;
  logic             o_wb_ack;
  logic [WIDTH-1:0] o_gpio;
  logic [WIDTH-1:0] o_gpio_oe;
  logic [WIDTH-1:0] i_gpio;
  logic             o_irq;

  rocketcpu_gpio_bank #(
    .WIDTH     (WIDTH),
    .OUT_RESET (OUT_RST),
    .IN_INVERT (INV)
  ) dut (
    .i_wb_clk  (clk),
    .i_wb_rst  (rst),
    .i_wb_adr  (i_wb_adr),
    .i_wb_dat  (i_wb_dat),
    .i_wb_we   (i_wb_we),
    .i_wb_cyc  (i_wb_cyc),
    .o_wb_rdt  (o_wb_rdt),
    .o_wb_ack  (o_wb_ack),
    .o_gpio    (o_gpio),
    .o_gpio_oe (o_gpio_oe),
    .i_gpio    (i_gpio),
    .o_irq     (o_irq)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          cmp_q[$];
  logic [7:0]  m_out;
  logic [7:0]  m_dir;
  logic        irq_at_ack;
  logic        prev_ack = 1'b0;
  logic [31:0] mon_exp;
  bit          mon_cmp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected read word per ack, checks ack width and idle rdt.
  always @(negedge clk) begin
    if (rst) begin
      prev_ack = 1'b0;
    end else if (o_wb_ack) begin
      chk("ack_single_cycle", 32'(prev_ack), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cmp = cmp_q.pop_front();
        if (mon_cmp) chk("read_data", o_wb_rdt, mon_exp);
      end
      prev_ack = 1'b1;
    end else begin
      chk("rdt_idle_zero", o_wb_rdt, 32'd0);
      prev_ack = 1'b0;
    end
  end

  // Called at a negedge; the ack edge is the next posedge; returns at a negedge two edges later.
  task automatic wb(input logic we, input logic [2:0] adr, input logic [31:0] dat, input logic [31:0] exp);
    exp_q.push_back(exp);
    cmp_q.push_back(!we);
    i_wb_cyc = 1'b1;
    i_wb_we  = we;
    i_wb_adr = adr;
    i_wb_dat = dat;
    if (we && adr == 3'd0) m_out = dat[7:0];
    if (we && adr == 3'd1) m_dir = dat[7:0];
    @(posedge clk);
    #1;
    irq_at_ack = o_irq;
    chk("ack_rise", 32'(o_wb_ack), 32'd1);
    chk("o_gpio", 32'(o_gpio), 32'(m_out));
    chk("o_gpio_oe", 32'(o_gpio_oe), 32'(m_dir));
    @(negedge clk);
    i_wb_cyc = 1'b0;
    i_wb_we  = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_wb_cyc = 1'b0; i_wb_we = 1'b0; i_wb_adr = '0; i_wb_dat = '0; i_gpio = '0;
    m_out = OUT_RST; m_dir = 8'h00; irq_at_ack = 1'b0;
    #12;
    chk("reset_o_gpio", 32'(o_gpio), 32'hA5);
    chk("reset_o_gpio_oe", 32'(o_gpio_oe), 32'h00);
    chk("reset_o_irq", 32'(o_irq), 32'd0);
    chk("reset_ack", 32'(o_wb_ack), 32'd0);
    chk("reset_rdt", o_wb_rdt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset reads; the inverted idle pin 0 reaches sync after release and registers as an edge.
    wb(1'b0, 3'd3, 32'd0, 32'd0);
    wb(1'b0, 3'd1, 32'd0, 32'd0);
    wb(1'b0, 3'd4, 32'd0, 32'd0);
    wb(1'b0, 3'd2, 32'd0, 32'h01);
    wb(1'b0, 3'd3, 32'd0, IRQ ? 32'h01 : 32'h00);
    wb(1'b1, 3'd3, 32'hFF, 32'd0);
    wb(1'b0, 3'd3, 32'd0, 32'd0);
    chk("irq_idle", 32'(o_irq), 32'd0);

    // OUT/DIR, upper data bits dropped, IN read-only, reserved words.
    wb(1'b1, 3'd1, 32'h0000_00FF, 32'd0);
    wb(1'b1, 3'd0, 32'h1234_563C, 32'd0);
    wb(1'b0, 3'd0, 32'd0, 32'h0000_003C);
    wb(1'b0, 3'd1, 32'd0, 32'h0000_00FF);
    wb(1'b1, 3'd2, 32'hFF, 32'd0);
    wb(1'b0, 3'd2, 32'd0, 32'h01);
    wb(1'b1, 3'd7, 32'hFFFF_FFFF, 32'd0);
    wb(1'b0, 3'd7, 32'd0, 32'd0);
    wb(1'b0, 3'd5, 32'd0, 32'd0);

    // Pins 0x00 -> 0x81 with bit 0 inverted: IN becomes 0x80 after two edges.
    i_gpio = 8'h81;
    idle(2);
    wb(1'b0, 3'd2, 32'd0, 32'h80);
    wb(1'b0, 3'd3, 32'd0, IRQ ? 32'h80 : 32'h00);
    wb(1'b1, 3'd3, 32'h80, 32'd0);
    wb(1'b0, 3'd3, 32'd0, 32'd0);

    // Pin 7 edge to o_irq latency, then clear.
    wb(1'b1, 3'd4, 32'h80, 32'd0);
    wb(1'b0, 3'd4, 32'd0, IRQ ? 32'h80 : 32'h00);
    i_gpio = 8'h01;
    idle(3);
    i_gpio = 8'h81;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk("irq_latency", 32'(o_irq), (k == 4 && IRQ) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    wb(1'b1, 3'd3, 32'h80, 32'd0);
    chk("irq_hold_on_clear_edge", 32'(irq_at_ack), 32'(IRQ));
    chk("irq_drop_after_clear", 32'(o_irq), 32'd0);

    // MASK set while PEND already set.
    wb(1'b1, 3'd4, 32'h00, 32'd0);
    i_gpio = 8'h01;
    idle(3);
    i_gpio = 8'h81;
    idle(3);
    chk("irq_masked", 32'(o_irq), 32'd0);
    wb(1'b1, 3'd4, 32'h80, 32'd0);
    chk("irq_on_mask_edge", 32'(irq_at_ack), 32'd0);
    chk("irq_after_mask", 32'(o_irq), 32'(IRQ));
    wb(1'b1, 3'd4, 32'h00, 32'd0);
    wb(1'b1, 3'd3, 32'hFF, 32'd0);

    // Clear of bit 2 in the same cycle as a new pin-2 edge: set wins.
    i_gpio = 8'h85;
    idle(3);
    i_gpio = 8'h81;
    idle(3);
    wb(1'b0, 3'd3, 32'd0, IRQ ? 32'h04 : 32'h00);
    i_gpio = 8'h85;
    idle(2);
    wb(1'b1, 3'd3, 32'h04, 32'd0);
    wb(1'b0, 3'd3, 32'd0, IRQ ? 32'h04 : 32'h00);
    wb(1'b1, 3'd3, 32'h04, 32'd0);
    wb(1'b0, 3'd3, 32'd0, 32'd0);

    // All pins toggled with all interrupt writes applied.
    wb(1'b1, 3'd4, 32'hFF, 32'd0);
    i_gpio = 8'h7A;
    idle(3);
    i_gpio = 8'hFF;
    idle(4);
    chk("irq_all_pins", 32'(o_irq), 32'(IRQ));
    wb(1'b0, 3'd4, 32'd0, IRQ ? 32'hFF : 32'h00);
    wb(1'b0, 3'd2, 32'd0, 32'hFE);

    idle(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
